// File: rtl/matrix_frame_store.sv
// Double-buffered 8x8 bicolour frame store: producer writes the back buffer, the scan
// driver reads the front buffer, and buffer swaps are held off until the scanner's frame_end.
module matrix_frame_store #(
  parameter int ROWS   = 8,
  parameter int COLS   = 8,
  parameter int COLORS = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic                    wr_color,
  input  logic [$clog2(ROWS)-1:0] wr_row,
  input  logic [COLS-1:0]         wr_data,
  input  logic                    clear_req,
  input  logic                    swap_req,
  output logic                    swap_pending,
  output logic                    front_sel,
  input  logic                    frame_end,
  input  logic                    rd_color,
  input  logic [$clog2(ROWS)-1:0] rd_row,
  output logic [COLS-1:0]         rd_data
);

  localparam int RW = $clog2(ROWS);
  localparam logic [RW-1:0] LAST_ROW   = RW'(ROWS - 1);
  localparam logic [RW:0]   ROWS_W     = (RW + 1)'(ROWS);
  localparam logic          LAST_COLOR = 1'(COLORS - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CLEAR     = 2'd1,
    SWAP_WAIT = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            front_q, front_d;
  logic [RW-1:0]   clr_row_q, clr_row_d;
  logic            clr_color_q, clr_color_d;
  logic            wr_ready_q;
  logic            swap_pending_q;
  logic [COLS-1:0] rd_data_q;
  logic [COLS-1:0] mem_q [2][COLORS][ROWS];

  logic            clr_en_s;
  logic            wr_en_s;
  logic            rd_in_range_s;

  // Rows past ROWS only exist when ROWS is not a power of two; such writes are dropped.
  assign wr_en_s       = wr_valid & wr_ready_q & ({1'b0, wr_row} < ROWS_W);
  assign rd_in_range_s = ({1'b0, rd_row} < ROWS_W);

  // Next-state logic for the clear/swap controller.
  always_comb begin
    state_d     = state_q;
    front_d     = front_q;
    clr_row_d   = clr_row_q;
    clr_color_d = clr_color_q;
    clr_en_s    = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d     = CLEAR;
          clr_row_d   = '0;
          clr_color_d = 1'b0;
        end else if (swap_req) begin
          state_d = SWAP_WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      CLEAR: begin
        clr_en_s = 1'b1;
        if (clr_row_q == LAST_ROW) begin
          clr_row_d = '0;
          if (clr_color_q == LAST_COLOR) begin
            state_d = IDLE;
          end else begin
            clr_color_d = clr_color_q + 1'b1;
          end
        end else begin
          clr_row_d = clr_row_q + 1'b1;
        end
      end
      SWAP_WAIT: begin
        if (frame_end) begin
          front_d = ~front_q;
          state_d = IDLE;
        end else begin
          state_d = SWAP_WAIT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Controller registers; handshake/status outputs are decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      front_q        <= 1'b0;
      clr_row_q      <= '0;
      clr_color_q    <= 1'b0;
      wr_ready_q     <= 1'b1;
      swap_pending_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      front_q        <= front_d;
      clr_row_q      <= clr_row_d;
      clr_color_q    <= clr_color_d;
      wr_ready_q     <= (state_d == IDLE);
      swap_pending_q <= (state_d == SWAP_WAIT);
    end
  end

  // Storage: producer writes and clear sweep only ever touch the back buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int c = 0; c < COLORS; c++) begin
          for (int r = 0; r < ROWS; r++) begin
            mem_q[b][c][r] <= '0;
          end
        end
      end
    end else if (clr_en_s) begin
      mem_q[~front_q][clr_color_q][clr_row_q] <= '0;
    end else if (wr_en_s) begin
      mem_q[~front_q][wr_color][wr_row] <= wr_data;
    end
  end

  // Free-running read port; uses the front selection in force before this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else if (rd_in_range_s) begin
      rd_data_q <= mem_q[front_q][rd_color][rd_row];
    end else begin
      rd_data_q <= '0;
    end
  end

  assign wr_ready     = wr_ready_q;
  assign swap_pending = swap_pending_q;
  assign front_sel    = front_q;
  assign rd_data      = rd_data_q;

endmodule

// File: tb/tb_matrix_frame_store.sv
// Self-checking bench for matrix_frame_store: directed scenarios with literal expectations
// plus randomized traffic, all checked every cycle against a behavioural frame-store model.
module tb_matrix_frame_store;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_valid = 1'b0, wr_color = 1'b0;
  logic [2:0] wr_row = 3'd0;
  logic [7:0] wr_data = 8'h00;
  logic       clear_req = 1'b0, swap_req = 1'b0, frame_end = 1'b0;
  logic       rd_color = 1'b0;
  logic [2:0] rd_row = 3'd0;
  logic       wr_ready, swap_pending, front_sel;
  logic [7:0] rd_data;

  int tests = 0;
  int fails = 0;

  matrix_frame_store dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_color(wr_color),
    .wr_row(wr_row), .wr_data(wr_data),
    .clear_req(clear_req), .swap_req(swap_req), .swap_pending(swap_pending),
    .front_sel(front_sel), .frame_end(frame_end),
    .rd_color(rd_color), .rd_row(rd_row), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: two frames, a display pointer, a pending-swap flag and a busy
  // countdown for the clear. A clear wipes the back frame at once since the back frame
  // cannot be displayed before the clear finishes.
  logic [7:0] m_buf [2][2][8];
  logic       m_front, m_pending;
  int         m_clear_left;
  logic [7:0] m_rd;
  wire        m_ready = (m_clear_left == 0) && !m_pending;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++)
        for (int c = 0; c < 2; c++)
          for (int r = 0; r < 8; r++) m_buf[b][c][r] <= 8'h00;
      m_front <= 1'b0; m_pending <= 1'b0; m_clear_left <= 0; m_rd <= 8'h00;
    end else begin
      m_rd <= m_buf[m_front][rd_color][rd_row];
      if (wr_valid && m_ready) m_buf[!m_front][wr_color][wr_row] <= wr_data;
      if (m_clear_left > 0) begin
        m_clear_left <= m_clear_left - 1;
      end else if (m_pending) begin
        if (frame_end) begin
          m_front   <= !m_front;
          m_pending <= 1'b0;
        end
      end else if (clear_req) begin
        m_clear_left <= 16;
        for (int c = 0; c < 2; c++)
          for (int r = 0; r < 8; r++) m_buf[!m_front][c][r] <= 8'h00;
      end else if (swap_req) begin
        m_pending <= 1'b1;
      end
    end
  end

  // Compare process: every cycle out of reset, all outputs against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      check("wr_ready", {31'd0, wr_ready}, {31'd0, m_ready});
      check("swap_pending", {31'd0, swap_pending}, {31'd0, m_pending});
      check("front_sel", {31'd0, front_sel}, {31'd0, m_front});
      check("rd_data", {24'd0, rd_data}, {24'd0, m_rd});
    end
  end

  task automatic idle_inputs();
    wr_valid = 1'b0; clear_req = 1'b0; swap_req = 1'b0; frame_end = 1'b0;
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic mid_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
    check("rst_swap_pending", {31'd0, swap_pending}, 32'd0);
    check("rst_front_sel", {31'd0, front_sel}, 32'd0);
    check("rst_rd_data", {24'd0, rd_data}, 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int cnt;
    int bound;
    int pend_seen;
    cyc(3);
    rst_n = 1'b1;
    rd_color = 1'b1; rd_row = 3'd6;
    cyc(1);
    check("t1_rd_after_reset", {24'd0, rd_data}, 32'h00);

    // Test 2: write, swap, frame_end five cycles later
    wr_valid = 1'b1; wr_color = 1'b0; wr_row = 3'd3; wr_data = 8'hA5;
    cyc(1);
    wr_valid = 1'b0; swap_req = 1'b1;
    cyc(1);
    swap_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("t2_pending", {31'd0, swap_pending}, 32'd1);
      check("t2_front_hold", {31'd0, front_sel}, 32'd0);
      if (i == 4) frame_end = 1'b1;
      cyc(1);
    end
    frame_end = 1'b0;
    check("t2_front_new", {31'd0, front_sel}, 32'd1);
    check("t2_pending_done", {31'd0, swap_pending}, 32'd0);
    rd_color = 1'b0; rd_row = 3'd3;
    cyc(1);
    check("t2_rd_red3", {24'd0, rd_data}, 32'hA5);
    rd_color = 1'b1;
    cyc(1);
    check("t2_rd_green3", {24'd0, rd_data}, 32'h00);

    // Test 1: asynchronous reset mid-cycle
    mid_reset();

    // Test 3: swap_req and frame_end in the same cycle
    swap_req = 1'b1; frame_end = 1'b1;
    cyc(1);
    swap_req = 1'b0; frame_end = 1'b0;
    check("t3_front_same", {31'd0, front_sel}, 32'd0);
    check("t3_pending", {31'd0, swap_pending}, 32'd1);
    cyc(3);
    frame_end = 1'b1;
    cyc(1);
    frame_end = 1'b0;
    check("t3_front_swapped", {31'd0, front_sel}, 32'd1);

    // Test 4: fill back buffer with FF, clear, swap, read all back
    for (int k = 0; k < 16; k++) begin
      wr_valid = 1'b1; wr_color = k[3]; wr_row = k[2:0]; wr_data = 8'hFF;
      cyc(1);
    end
    wr_valid = 1'b0; clear_req = 1'b1;
    cyc(1);
    clear_req = 1'b0;
    cnt = 0; bound = 0;
    while (!wr_ready && bound < 40) begin
      cnt++; bound++;
      cyc(1);
    end
    check("t4_clear_cycles", cnt, 32'd16);
    swap_req = 1'b1;
    cyc(1);
    swap_req = 1'b0; frame_end = 1'b1;
    cyc(1);
    frame_end = 1'b0;
    check("t4_front", {31'd0, front_sel}, 32'd0);
    for (int k = 0; k < 16; k++) begin
      rd_color = k[3]; rd_row = k[2:0];
      cyc(1);
      check("t4_rd_cleared", {24'd0, rd_data}, 32'h00);
    end

    // Test 5: wr_valid held through SWAP_WAIT
    wr_valid = 1'b1; wr_color = 1'b0; wr_row = 3'd0; wr_data = 8'h3C; swap_req = 1'b1;
    cyc(1);
    swap_req = 1'b0; wr_row = 3'd5; wr_data = 8'h77;
    rd_color = 1'b0; rd_row = 3'd5;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      check("t5_ready_low", {31'd0, wr_ready}, 32'd0);
      check("t5_front_unchanged", {24'd0, rd_data}, 32'h00);
    end
    frame_end = 1'b1;
    cyc(1);
    frame_end = 1'b0;
    cyc(1);
    wr_valid = 1'b0;
    rd_row = 3'd0;
    cyc(1);
    check("t5_rd_front0", {24'd0, rd_data}, 32'h3C);
    rd_row = 3'd5;
    cyc(1);
    check("t5_rd_front5", {24'd0, rd_data}, 32'h00);

    // Test 6: clear_req+swap_req together, then reset during SWAP_WAIT
    clear_req = 1'b1; swap_req = 1'b1;
    cyc(1);
    clear_req = 1'b0; swap_req = 1'b0;
    pend_seen = 0;
    for (int i = 0; i < 25; i++) begin
      if (swap_pending) pend_seen++;
      cyc(1);
    end
    check("t6_no_pending", pend_seen, 32'd0);
    check("t6_front_kept", {31'd0, front_sel}, 32'd1);
    swap_req = 1'b1;
    cyc(1);
    swap_req = 1'b0;
    cyc(2);
    check("t6_pending_before_rst", {31'd0, swap_pending}, 32'd1);
    mid_reset();
    cyc(1);
    check("t6_idle_ready", {31'd0, wr_ready}, 32'd1);

    // Randomized traffic checked by the compare process
    for (int i = 0; i < 3000; i++) begin
      wr_valid  = ($urandom_range(0, 1) == 1);
      wr_color  = 1'($urandom_range(0, 1));
      wr_row    = 3'($urandom_range(0, 7));
      wr_data   = 8'($urandom);
      clear_req = ($urandom_range(0, 99) < 3);
      swap_req  = ($urandom_range(0, 99) < 6);
      frame_end = ($urandom_range(0, 99) < 10);
      rd_color  = 1'($urandom_range(0, 1));
      rd_row    = 3'($urandom_range(0, 7));
      cyc(1);
    end
    idle_inputs();
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
